// File: rtl/mod_mult_serial.sv
// mod_mult_serial: bit-serial modular multiplier.
//   mode 0: result = a*b mod n, one multiplier bit per cycle, MSB first.
//   mode 1: result = a*2^W mod n (pre-scaling step; b is ignored).
// Handshake: start is sampled only while busy=0. busy rises the cycle after
// acceptance and stays high through the single-cycle valid pulse; result
// holds the last completed value until the next completion.
module mod_mult_serial #(
   parameter int W = 256
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] n,
   output logic [W-1:0] result,
   output logic         valid,
   output logic         busy,
   output logic [1:0]   o_dbg_state
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_n;
   logic          r_mode;
   logic [W-1:0]  r_acc;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_result;
   logic          r_valid;
   logic          r_busy;

   logic          w_bit;
   logic [W:0]    w_n_ext;
   logic [W:0]    w_dbl;
   logic [W:0]    w_d;
   logic [W:0]    w_sum;
   logic [W:0]    w_s;
   logic          w_unused_s_msb;

   // One double-and-add iteration. Both reductions use >= so an intermediate
   // exactly equal to n collapses to 0; with a < n the accumulator stays < n.
   assign w_bit   = r_mode ? 1'b0 : r_b[r_cnt];
   assign w_n_ext = {1'b0, r_n};
   assign w_dbl   = {r_acc, 1'b0};
   assign w_d     = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
   assign w_sum   = w_d + (w_bit ? {1'b0, r_a} : {(W+1){1'b0}});
   assign w_s     = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
   // The top bit of s is only non-zero for out-of-range operands, whose
   // result is unspecified; the accumulator keeps the low W bits.
   assign w_unused_s_msb = w_s[W];

   // Control FSM and datapath registers: IDLE -> RUN (W cycles) -> DONE -> IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_n      <= '0;
         r_mode   <= 1'b0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_valid <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_n     <= n;
                  r_mode  <= mode;
                  r_acc   <= mode ? a : '0;
                  r_cnt   <= CW'(W - 1);
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc <= w_s[W-1:0];
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  // Result and valid are registered here so they are visible
                  // during the DONE cycle.
                  r_result <= w_s[W-1:0];
                  r_valid  <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign result      = r_result;
   assign valid       = r_valid;
   assign busy        = r_busy;
   assign o_dbg_state = r_state;

endmodule

// File: doc/mod_mult_serial.md
# mod_mult_serial

Parametrised bit-serial modular multiplier for the RSA datapath. In mode 0 it computes a·b mod N, one multiplier bit per cycle, MSB first, using interleaved double-and-add with conditional subtraction. In mode 1 it computes a·2^W mod N, which is the Montgomery/RSA pre-scaling step, so one block covers both the pre-scaling stage and general modular products. It sits between the key/ciphertext registers and the exponentiation controller, and uses a start/busy/valid handshake.

## Interface
- W, default 256: operand, modulus and result width in bits; must be ≥ 4.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- mode  in  1  0: a·b mod N; 1: a·2^W mod N (b ignored).
- a  in  W  multiplicand; required a < N.
- b  in  W  multiplier; any value.
- n  in  W  modulus; required N ≥ 2.
- result  out  W  last completed result; holds until the next completion.
- valid  out  1  single-cycle pulse when result updates.
- busy  out  1  high from the cycle after start is accepted through the valid cycle.

## Operation
- Reset: state IDLE; result=0, valid=0, busy=0. All internal registers are cleared.
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE, start=1:
  - Latch a, b, N and mode.
  - Set acc=0 for mode 0, or acc=a for mode 1.
  - Set bit counter=W-1 and go to RUN.
- IDLE, start=0: hold all state.
- RUN, each cycle:
  - d = 2·acc; if d ≥ N then d −= N.
  - s = d + (bit ? a : 0); if s ≥ N then s −= N.
  - acc ← s.
  - bit is b[counter] in mode 0 and 0 in mode 1.
  - The counter decrements; after the counter=0 iteration go to DONE.
- DONE: result ← acc, valid=1 for this cycle only, then return to IDLE.
- Widths:
  - d and s are W+1 bits; acc and result are W bits.
  - Comparisons use ≥, not >, so an equal-to-N intermediate reduces to 0.
  - Invariant: acc < N after every RUN cycle when a < N.
- start while busy=1 is ignored. It is not queued, and latched operands are unaffected by input changes.
- Out-of-range input (a ≥ N or N < 2):
  - result is unspecified.
  - The FSM still completes in exactly W+2 cycles and never hangs.
- Counter width: $clog2(W); wrap-around is never reached because RUN exits at 0.

## Timing
- Cycle 0: start=1 is sampled in IDLE.
- Cycles 1..W: RUN, with busy=1.
- Cycle W+1: DONE, with valid=1, busy=1 and result valid.
- Cycle W+2: IDLE, busy=0. start can be accepted in this cycle, which gives a back-to-back throughput of one op per W+2 cycles.
- Latency from start to valid is W+1 cycles.
- Reset asserted mid-RUN or in DONE:
  - Immediately forces IDLE, busy=0, valid=0 and result=0.
  - No valid pulse is emitted for the aborted operation.
- start held high continuously: one operation is accepted per IDLE visit.

## Test plan
- W=8, N=13, a=7, b=9, mode 0 → result=11; valid exactly at cycle 9 after start; busy high for cycles 1–9.
- W=8, N=13, a=5, mode 1, b=0xFF → result=6 (5·256 mod 13); b must have no effect.
- W=8, N=255, a=254, b=254, mode 0 → result=1. This checks the ≥N boundary and the equal-to-N reduction, and a=0 → result=0.
- W=256, N=7, a=2, b=3 → result=6 at cycle 257. Then run a second op with start in the cycle after busy falls: a=3, b=5 → result=1.
- W=8, N=13: start op a=7, b=9. At cycle 4 assert start with a=1, b=1 → ignored, and the result is still 11 at cycle 9.
- W=8: assert rst at cycle 5 of an op → busy=0, result=0, no valid pulse. A new start after reset release with a=2, b=6, N=13 → result=12.
